// File: rtl/vga_index_scanout.sv
// rtl/vga_index_scanout.sv - 640x480@60 VGA sweep reading a 3-bit index frame buffer through an 8-colour palette
// Sync, blank and RGB share a D = MEM_LATENCY+1 stage pipeline so they line up at the DAC.
module vga_index_scanout #(
   parameter int H_VISIBLE   = 640,
   parameter int H_FRONT     = 16,
   parameter int H_SYNC      = 96,
   parameter int H_BACK      = 48,
   parameter int V_VISIBLE   = 480,
   parameter int V_FRONT     = 10,
   parameter int V_SYNC      = 2,
   parameter int V_BACK      = 33,
   parameter int MEM_LATENCY = 2
) (
   input  logic        clock,
   input  logic        reset,
   output logic [18:0] mem_raddr,
   input  logic [2:0]  mem_rdata,
   output logic        vga_hs,
   output logic        vga_vs,
   output logic        vga_blank_n,
   output logic        vga_sync_n,
   output logic [7:0]  vga_r,
   output logic [7:0]  vga_g,
   output logic [7:0]  vga_b,
   output logic        frame_start
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int D       = MEM_LATENCY + 1;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);

   localparam logic [HW-1:0] H_LAST      = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_VIS_LAST  = HW'(H_VISIBLE - 1);
   localparam logic [HW-1:0] H_SYNC_BEG  = HW'(H_VISIBLE + H_FRONT);
   localparam logic [HW-1:0] H_SYNC_END  = HW'(H_VISIBLE + H_FRONT + H_SYNC - 1);
   localparam logic [VW-1:0] V_LAST      = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_VIS_LAST  = VW'(V_VISIBLE - 1);
   localparam logic [VW-1:0] V_SYNC_BEG  = VW'(V_VISIBLE + V_FRONT);
   localparam logic [VW-1:0] V_SYNC_END  = VW'(V_VISIBLE + V_FRONT + V_SYNC - 1);

   logic [HW-1:0] r_h;
   logic [VW-1:0] r_v;
   logic [18:0]   r_addr;
   logic          r_frame_start;
   logic [D-1:0]  r_vis_pipe;
   logic [D-1:0]  r_hs_pipe;
   logic [D-1:0]  r_vs_pipe;
   logic [23:0]   r_rgb;

   logic          w_vis;
   logic          w_hs;
   logic          w_vs;
   logic          w_h_wrap;
   logic          w_frame_wrap;
   logic          w_last_pix;
   logic [23:0]   w_pal;

   assign w_vis        = (r_h <= H_VIS_LAST) && (r_v <= V_VIS_LAST);
   assign w_hs         = !((r_h >= H_SYNC_BEG) && (r_h <= H_SYNC_END));
   assign w_vs         = !((r_v >= V_SYNC_BEG) && (r_v <= V_SYNC_END));
   assign w_h_wrap     = (r_h == H_LAST);
   assign w_frame_wrap = w_h_wrap && (r_v == V_LAST);
   assign w_last_pix   = (r_h == H_VIS_LAST) && (r_v == V_VIS_LAST);

   // The address advances on leaving each visible pixel, so after the last
   // pixel of a line it already points at the first pixel of the next line.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_h           <= '0;
         r_v           <= '0;
         r_addr        <= '0;
         r_frame_start <= 1'b0;
      end else begin
         r_frame_start <= w_frame_wrap;
         if (w_h_wrap) begin
            r_h <= '0;
            r_v <= (r_v == V_LAST) ? '0 : r_v + 1'b1;
         end else begin
            r_h <= r_h + 1'b1;
         end
         if (w_frame_wrap)
            r_addr <= '0;
         else if (w_vis && !w_last_pix)
            r_addr <= r_addr + 1'b1;
      end
   end

   always_comb begin
      w_pal = 24'h000000;
      case (mem_rdata)
         3'd0: w_pal = 24'h000000;
         3'd1: w_pal = 24'hFF0000;
         3'd2: w_pal = 24'h00FF00;
         3'd3: w_pal = 24'h0000FF;
         3'd4: w_pal = 24'hFFFF00;
         3'd5: w_pal = 24'h00FFFF;
         3'd6: w_pal = 24'hFF00FF;
         3'd7: w_pal = 24'hFFFFFF;
         default: w_pal = 24'h000000;
      endcase
   end

   // Stage D-2 of the visible flag belongs to the pixel whose index is on mem_rdata now.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_vis_pipe <= '0;
         r_hs_pipe  <= '1;
         r_vs_pipe  <= '1;
         r_rgb      <= 24'h000000;
      end else begin
         r_vis_pipe <= {r_vis_pipe[D-2:0], w_vis};
         r_hs_pipe  <= {r_hs_pipe[D-2:0], w_hs};
         r_vs_pipe  <= {r_vs_pipe[D-2:0], w_vs};
         r_rgb      <= r_vis_pipe[D-2] ? w_pal : 24'h000000;
      end
   end

   assign mem_raddr   = r_addr;
   assign frame_start = r_frame_start;
   assign vga_hs      = r_hs_pipe[D-1];
   assign vga_vs      = r_vs_pipe[D-1];
   assign vga_blank_n = r_vis_pipe[D-1];
   assign vga_sync_n  = 1'b0;
   assign vga_r       = r_rgb[23:16];
   assign vga_g       = r_rgb[15:8];
   assign vga_b       = r_rgb[7:0];

endmodule

// File: doc/vga_index_scanout.md
# vga_index_scanout

Downstream consumer of the 640x480 colour-index frame buffer that the MIF/index writer fills with characters and trajectory pixels. It sweeps standard 640x480@60 VGA timing and issues one frame-buffer read per visible pixel. Each 3-bit index is mapped through a fixed 8-entry palette to 24-bit RGB. Sync, blank and RGB are pipelined so they stay aligned at the DAC.

## Interface
Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BACK, 48, horizontal back porch
- V_VISIBLE, 480, visible lines
- V_FRONT, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BACK, 33, vertical back porch
- MEM_LATENCY, 2, read latency in cycles from mem_raddr to mem_rdata (≥1)

Ports:
- clock  in  1  pixel clock, 25 MHz, one pixel per cycle
- reset  in  1  asynchronous, active-high
- mem_raddr  out  19  frame-buffer read address
- mem_rdata  in  3  colour index returned MEM_LATENCY cycles after mem_raddr
- vga_hs  out  1  horizontal sync, active low
- vga_vs  out  1  vertical sync, active low
- vga_blank_n  out  1  high during visible pixels
- vga_sync_n  out  1  tied 0
- vga_r, vga_g, vga_b  out  8 each  pixel colour
- frame_start  out  1  one-cycle pulse at each frame wrap, for upstream redraw sequencing

## Operation
- h_count: 0..799 (H total 800), increments every cycle, wraps to 0. When it wraps, v_count increments: 0..524 (V total 525), then wraps to 0.
- Visible when h<640 and v<480.
- hs_raw is low for h in [656,751]; vs_raw is low for v in [490,491].
- Address counter is updated together with the counters:
  - In the cycle counters=(h,v) visible, mem_raddr = v*640+h.
  - Computed incrementally; no multiplier.
  - Holds its value through blanking.
  - Becomes 0 when the counters wrap to (0,0).
  - Range is 0..307199 and never exceeds it.
- Pipeline depth D = MEM_LATENCY+1. visible, hs_raw and vs_raw pass through D register stages. The RGB register captures palette(mem_rdata) in the final stage.
- Palette: 0→000000, 1→FF0000, 2→00FF00, 3→0000FF, 4→FFFF00, 5→00FFFF, 6→FF00FF, 7→FFFFFF.
- When the delayed visible flag is 0, RGB is forced to 000000 regardless of mem_rdata.
- frame_start is high for exactly the cycle in which the counters equal (0,0) after a wrap from (799,524). It does not pulse for the first frame after reset. It is not delayed by D.
- No state machine beyond the counters; the free-running sweep starts on reset release.

## Timing
- Reset (asynchronous assert, held):
  - Counters 0, mem_raddr 0.
  - All pipeline stages set to the blanking value.
  - vga_hs=1, vga_vs=1, vga_blank_n=0, RGB=0, frame_start=0, vga_sync_n=0.
- First cycle after deassertion: counters=(0,0), mem_raddr=0.
- Output latency: hs/vs/blank_n/RGB for pixel (h,v) appear D cycles after the cycle whose counters are (h,v). With the default MEM_LATENCY, D=3.
- Periods:
  - hsync period 800 cycles, low for 96.
  - vsync period 420000 cycles, low for 1600 (2 lines).
  - blank_n high for 640 consecutive cycles per visible line, 480 lines per frame.
- Wrap boundary: the (639,479) read uses address 307199. The next read issued is address 0, in the (0,0) cycle of the next frame.
- Reset mid-frame: all state clears asynchronously. The sweep restarts at (0,0) with no partial line emitted and no frame_start pulse.

## Test plan
- Reset: assert mid-line, check every output at its reset value within the same cycle. Release; mem_raddr=0, and vga_blank_n rises exactly 3 cycles later.
- Sync timing: over 2 frames, measure vga_hs low 96/period 800 and vga_vs low 1600/period 420000. Check hs falls 656+3 cycles after line start.
- Addressing: sample mem_raddr at counters (0,0)→0, (1,0)→1, (0,1)→640, (639,479)→307199. Confirm it never exceeds 307199 over a full frame.
- Palette/alignment: memory model with latency 2 returns addr%8. Pixel (1,0) shows FF0000 and pixel (7,0) shows FFFFFF, both with blank_n=1. RGB is 000000 on every blanked cycle.
- frame_start: no pulse during the first frame. Pulses thereafter are exactly 420000 cycles apart, each one cycle wide, coincident with mem_raddr=0.
- MEM_LATENCY=1 build: D=2, and the alignment checks above hold with shifted latency.
